// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: computes a - b - bin one bit per clock,
// LSB first, and reports difference, borrow, zero and signed overflow.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_sh, b_sh, dsh, d_n;
    logic [CW-1:0]    cnt;
    logic             br, a_msb, b_msb;
    logic             a_i, b_i, hs1_d, hs1_b, hs2_b, d_i, br_n;
    logic             accept, last;

    // Full subtractor as two cascaded half subtractors
    assign a_i   = a_sh[0];
    assign b_i   = b_sh[0];
    assign hs1_d = a_i ^ b_i;
    assign hs1_b = ~a_i & b_i;
    assign d_i   = hs1_d ^ br;
    assign hs2_b = ~hs1_d & br;
    assign br_n  = hs1_b | hs2_b;

    assign d_n    = (dsh >> 1) | ({{(WIDTH-1){1'b0}}, d_i} << (WIDTH-1));
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            dsh   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            dsh  <= d_n;
            br   <= br_n;
            cnt  <= cnt + CW'(1);
            // Results only move on the completion edge
            if (last) begin
                d    <= d_n;
                bout <= br_n;
                zero <= (d_n == '0);
                ovf  <= (a_msb != b_msb) && (d_n[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Sequencer that performs a WIDTH-bit subtraction one bit per clock, LSB first.
- Uses an internal 1-bit full subtractor built from two cascaded 1-bit half subtractors, plus a registered borrow.
- Sits beside the ALU as the low-area subtract/compare path; the ALU top issues requests over a start/busy/done handshake.
- Produces the difference, final borrow, zero flag and signed-overflow flag.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when idle or in the done cycle.
- a  input  WIDTH  minuend; sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- bin  input  1  initial borrow-in; sampled with a/b.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; result outputs valid from this cycle on.
- d  output  WIDTH  difference a - b - bin (mod 2^WIDTH).
- bout  output  1  final borrow out of the MSB.
- zero  output  1  high when d == 0.
- ovf  output  1  two's-complement overflow of the subtraction.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, d=0, bout=0, zero=0, ovf=0, bit counter=0, internal shift registers and borrow=0.
- Reset mid-operation: abort on that edge and return to IDLE; no done pulse; outputs go to their reset values.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On the edge where start=1, latch a, b and bin into internal registers (borrow reg = bin), clear the counter, and go to RUN.
  - busy is 1 after that edge.
- RUN, each edge:
  - Take operand bit i (LSB of the shift registers).
  - Compute d_i = a_i ^ b_i ^ br.
  - Compute br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Shift d_i into the result register from the MSB side, shift the operand registers right, and increment the counter.
- Leaving RUN:
  - On the edge that processes bit WIDTH-1, go to DONE.
  - On that same edge, load d, bout=br_next, zero, and ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the latched operands.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - Then go to IDLE, or back to RUN if start=1 in this cycle (back-to-back accept with new a/b/bin latched).
- Latency: done is high exactly WIDTH cycles after the edge that accepted start; busy is high for exactly WIDTH cycles.
- start while busy (RUN): ignored, with no queuing and no effect on the running operation.
- Input changes on a, b or bin while busy have no effect.
- Output hold: d, bout, zero and ovf change only on the completion edge (or reset). They hold the previous result throughout RUN and after done until the next completion.
- done and busy are never both 1.
- Arithmetic: all modulo 2^WIDTH. bout=1 iff a < b + bin as unsigned values.

Test Plan:
- rst, then a=8'h05, b=8'h03, bin=0, start 1 cycle → busy for 8 cycles; done 8 cycles after the accept edge; d=8'h02, bout=0, zero=0, ovf=0.
- a=8'h03, b=8'h05, bin=0 → d=8'hFE, bout=1, ovf=0; then a=8'h2A, b=8'h2A → d=8'h00, zero=1, bout=0.
- Overflow cases: a=8'h80, b=8'h01, bin=0 → d=8'h7F, ovf=1, bout=0. a=8'h7F, b=8'hFF → d=8'h80, ovf=1, bout=1.
- Borrow-in: a=8'h00, b=8'h00, bin=1 → d=8'hFF, bout=1, zero=0.
- Pulse start again (with different a/b) during cycle 3 of RUN → ignored; result and latency match the first operation. Assert start in the done cycle with a=8'h10, b=8'h01 → accepted; second done exactly 8 cycles later with d=8'h0F.
- Assert rst at cycle 4 of RUN → busy=0 and d/bout/zero/ovf=0 on the next cycle; no done pulse. A following start completes normally.
